rob_ctrl: RTL
=============

Name: rob_ctrl

Overview:
Allocation and writeback controller for the 16-entry reorder buffer.
- Hands out ROB indices in program order at dispatch and tracks occupancy against retirements from the ROB head.
- Round-robin arbitrates two writeback pipes (A = ALU, B = MEM) onto the ROB's single write port, with a one-cycle registered output stage.
- Sits between dispatch/execute and the ROB; the ROB clear (exception flush) is driven from the same flush signal.

Parameters:
ROB_POSITIONS, 16, number of ROB entries (power of two)
ROB_IDX_BITS, 4, log2(ROB_POSITIONS)
ARCH_BITS, 32, architectural data/address width
PL_BITS, 3*ARCH_BITS+7, writeback payload width; packed MSB to LSB as {except, we, dst[4:0], pc, address, data}

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush; same signal as the ROB clear
allocReq  in  1  dispatch requests one ROB slot
allocGrant  out  1  slot granted this cycle (combinational)
allocIdx  out  ROB_IDX_BITS  index of the granted slot (current tail)
full  out  1  count == ROB_POSITIONS
empty  out  1  count == 0
retire  in  1  ROB head committed one entry this cycle
aValid  in  1  pipe A writeback request
aRobIdx  in  ROB_IDX_BITS  pipe A target index
aPayload  in  PL_BITS  pipe A payload
aReady  out  1  pipe A request accepted this cycle (combinational)
bValid  in  1  pipe B writeback request
bRobIdx  in  ROB_IDX_BITS  pipe B target index
bPayload  in  PL_BITS  pipe B payload
bReady  out  1  pipe B request accepted this cycle (combinational)
wbValid  out  1  drives ROB valid1 (registered)
wbRobIdx  out  ROB_IDX_BITS  drives ROB robIdx1 (registered)
wbPayload  out  PL_BITS  split by the integrator into except1/we1/dst1/pc1/address1/data1 (registered)

Behaviour:
- State:
  - tail [ROB_IDX_BITS]
  - count [ROB_IDX_BITS+1], range 0..16
  - prio bit: 0 = A first, 1 = B first
  - registered wbValid, wbRobIdx, wbPayload
- Reset (rst=0, asynchronous): tail=0, count=0, prio=0, wbValid=0, wbRobIdx=0, wbPayload=0.
  - Combinational outputs while in reset: allocGrant=0, aReady=0, bReady=0, allocIdx=0, full=0, empty=1.
- Allocation:
  - allocGrant = allocReq & !full & !clear; allocIdx = tail at all times.
  - On grant: tail <= (tail+1) mod ROB_POSITIONS, wrapping 15 -> 0.
  - A retire in the same cycle does not unblock a full ROB: full is evaluated on pre-update count.
- Count update:
  - +1 on grant, -1 on retire, unchanged when both occur.
  - retire with count==0 is ignored and count stays 0 (bench flags it as a protocol error).
- Arbitration, one grant per cycle, never while clear=1:
  - Only one of aValid/bValid set: that pipe is granted.
  - Both set: prio selects the winner; after any grant, prio points to the other pipe.
  - xReady=1 only in the grant cycle. A losing requester must hold valid, index and payload stable until ready.
- Writeback stage, latency 1:
  - Next edge after a grant: wbValid=1, wbRobIdx/wbPayload = winner's values.
  - No grant: wbValid=0; wbRobIdx/wbPayload hold their last values.
  - Back-to-back grants give wbValid=1 on consecutive cycles.
- clear (synchronous, highest priority after reset):
  - Next edge: tail=0, count=0, wbValid=0, prio=0.
  - Grants and retire in the clear cycle are discarded.
- No check that a writeback index is currently allocated; dispatch guarantees this.

Test Plan:
1. Assert rst=0 mid-cycle with wbValid=1, count=5 -> wbValid=0, empty=1, allocIdx=0 immediately, without waiting for a clock edge.
2. 16 consecutive allocReq, no retire -> allocIdx 0..15, full=1 after the 16th edge; 17th request gives allocGrant=0 and tail stays 0.
3. Full, then retire=1 with allocReq=1 -> allocGrant=0 and count=15 next cycle; following cycle grant with allocIdx=0 and count=16.
4. aValid=bValid=1 held for 4 cycles, indices 3 and 7 -> ready pattern A,B,A,B; wbRobIdx 3,7,3,7, each one cycle after its grant, wbValid continuously 1.
5. Only bValid=1 with idx 9, payload data=0xDEADBEEF, we=1, dst=5 -> bReady=1 the same cycle; next cycle wbValid=1, wbRobIdx=9, payload fields match.
6. count=6, tail=6, aValid=1, allocReq=1, clear=1 in one cycle -> aReady=0, allocGrant=0; next cycle count=0, tail=0, wbValid=0.

Source files
------------

// File: rtl/rob_ctrl.sv
// Reorder-buffer allocation/occupancy tracking and two-pipe writeback arbiter
// with a registered single-port writeback stage toward the ROB.
module rob_ctrl #(
  parameter int ROB_POSITIONS = 16,
  parameter int ROB_IDX_BITS  = 4,
  parameter int ARCH_BITS     = 32,
  parameter int PL_BITS       = 3*ARCH_BITS+7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    allocReq,
  output logic                    allocGrant,
  output logic [ROB_IDX_BITS-1:0] allocIdx,
  output logic                    full,
  output logic                    empty,
  input  logic                    retire,
  input  logic                    aValid,
  input  logic [ROB_IDX_BITS-1:0] aRobIdx,
  input  logic [PL_BITS-1:0]      aPayload,
  output logic                    aReady,
  input  logic                    bValid,
  input  logic [ROB_IDX_BITS-1:0] bRobIdx,
  input  logic [PL_BITS-1:0]      bPayload,
  output logic                    bReady,
  output logic                    wbValid,
  output logic [ROB_IDX_BITS-1:0] wbRobIdx,
  output logic [PL_BITS-1:0]      wbPayload
);

  localparam logic [ROB_IDX_BITS:0] FULL_CNT = (ROB_IDX_BITS+1)'(ROB_POSITIONS);

  logic [ROB_IDX_BITS-1:0] tail_q, tail_d;
  logic [ROB_IDX_BITS:0]   count_q, count_d;
  logic                    prio_q, prio_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [ROB_IDX_BITS-1:0] wb_idx_q, wb_idx_d;
  logic [PL_BITS-1:0]      wb_pl_q, wb_pl_d;

  logic full_w, empty_w, grant_w, a_win, b_win, retire_ok;

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);

  // rst gating keeps every handshake low while reset is asserted
  assign grant_w   = rst & allocReq & ~full_w & ~clear;
  assign a_win     = rst & ~clear & aValid & (~bValid | ~prio_q);
  assign b_win     = rst & ~clear & bValid & (~aValid |  prio_q);
  assign retire_ok = retire & ~empty_w;

  always_comb begin
    tail_d     = tail_q;
    count_d    = count_q;
    prio_d     = prio_q;
    wb_valid_d = a_win | b_win;
    wb_idx_d   = wb_idx_q;
    wb_pl_d    = wb_pl_q;

    if (clear) begin
      tail_d     = '0;
      count_d    = '0;
      prio_d     = 1'b0;
      wb_valid_d = 1'b0;
    end else begin
      if (grant_w)
        tail_d = tail_q + ROB_IDX_BITS'(1);
      if (grant_w && !retire_ok)
        count_d = count_q + (ROB_IDX_BITS+1)'(1);
      else if (!grant_w && retire_ok)
        count_d = count_q - (ROB_IDX_BITS+1)'(1);

      if (a_win) begin
        wb_idx_d = aRobIdx;
        wb_pl_d  = aPayload;
        prio_d   = 1'b1;
      end else if (b_win) begin
        wb_idx_d = bRobIdx;
        wb_pl_d  = bPayload;
        prio_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_q     <= '0;
      count_q    <= '0;
      prio_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_pl_q    <= '0;
    end else begin
      tail_q     <= tail_d;
      count_q    <= count_d;
      prio_q     <= prio_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_pl_q    <= wb_pl_d;
    end
  end

  assign allocGrant = grant_w;
  assign allocIdx   = tail_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign aReady     = a_win;
  assign bReady     = b_win;
  assign wbValid    = wb_valid_q;
  assign wbRobIdx   = wb_idx_q;
  assign wbPayload  = wb_pl_q;

endmodule
